// File: rtl/speed_test_pkg.sv
// Shared types and constants for the speed-test sequencer and anything that
// needs to decode its state or status.
package speed_test_pkg;

    localparam int RESULT_W = 128;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_READY,
        S_RUN,
        S_DRAIN,
        S_DONE
    } seq_state_e;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_READY_TO = 2'd1;
    localparam logic [1:0] ST_DRAIN_TO = 2'd2;
    localparam logic [1:0] ST_ABORT    = 2'd3;

    // Counter width helper that never collapses to a zero-width vector.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/speed_test_sequencer_if.sv
// Command/status and per-port handshake bundle between the register block,
// the frame generators/checkers and the sequencer.
interface speed_test_sequencer_if #(
    parameter int TEST_PORT_NUM = 4
);
    import speed_test_pkg::*;

    logic                                    cmd_start;
    logic                                    cmd_abort;
    logic [TEST_PORT_NUM-1:0]                port_mask;
    logic [31:0]                             duration_ms;
    logic [TEST_PORT_NUM-1:0]                gen_ready;
    logic [TEST_PORT_NUM-1:0]                check_ready;
    logic [TEST_PORT_NUM-1:0][RESULT_W-1:0]  check_results;

    logic [TEST_PORT_NUM-1:0]                start;
    logic [TEST_PORT_NUM-1:0]                stop;
    logic                                    busy;
    logic                                    result_valid;
    logic [1:0]                              status;
    logic [TEST_PORT_NUM-1:0][RESULT_W-1:0]  results;
    logic [31:0]                             elapsed_ms;

    modport master (
        output cmd_start, cmd_abort, port_mask, duration_ms,
               gen_ready, check_ready, check_results,
        input  start, stop, busy, result_valid, status, results, elapsed_ms
    );

    modport slave (
        input  cmd_start, cmd_abort, port_mask, duration_ms,
               gen_ready, check_ready, check_results,
        output start, stop, busy, result_valid, status, results, elapsed_ms
    );

endinterface

// File: rtl/speed_test_sequencer_ms_tick_gen.sv
// Millisecond prescaler: counts 0..DIV-1 while enabled and flags the wrap
// cycle; clear forces the count back to zero.
module ms_tick_gen
    import speed_test_pkg::*;
#(
    parameter int DIV = 125000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int CNT_W = clog2_min1(DIV);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && !i_clr && w_wrap;

endmodule

// File: rtl/speed_test_sequencer.sv
// Timed-run sequencer: gathers port readiness, pulses start, times the run in
// ms, pulses stop, waits for checkers to drain and snapshots their results.
module speed_test_sequencer
    import speed_test_pkg::*;
#(
    parameter int TEST_PORT_NUM = 4,
    parameter int CLOCK_FREQ    = 125000000,
    parameter int READY_TIMEOUT = 1250000,
    parameter int DRAIN_GUARD   = 16
) (
    input logic                 clk,
    input logic                 rst,
    speed_test_sequencer_if.slave bus
);

    localparam int TICK_DIV = CLOCK_FREQ / 1000;
    localparam int TMO_W    = clog2_min1(READY_TIMEOUT + 1);

    seq_state_e                              r_state;
    logic [TEST_PORT_NUM-1:0]                r_mask;
    logic [31:0]                             r_dur;
    logic [31:0]                             r_elapsed;
    logic [TMO_W-1:0]                        r_tmo;
    logic [TMO_W-1:0]                        r_guard;
    logic [1:0]                              r_code;
    logic [1:0]                              r_status;
    logic                                    r_busy;
    logic                                    r_result_valid;
    logic [TEST_PORT_NUM-1:0]                r_start;
    logic [TEST_PORT_NUM-1:0]                r_stop;
    logic [TEST_PORT_NUM-1:0][RESULT_W-1:0]  r_results;

    logic w_tick;
    logic w_gen_ok;
    logic w_drain_ok;
    logic w_tmo_hit;
    logic w_guard_done;
    logic w_in_run;

    assign w_in_run     = (r_state == S_RUN);
    assign w_gen_ok     = ((bus.gen_ready & bus.check_ready & r_mask) == r_mask);
    assign w_drain_ok   = ((bus.check_ready & r_mask) == r_mask);
    assign w_tmo_hit    = (r_tmo == TMO_W'(READY_TIMEOUT));
    assign w_guard_done = (r_guard == TMO_W'(DRAIN_GUARD));

    // Held in clear outside RUN so every run starts on a fresh ms boundary.
    ms_tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (!w_in_run),
        .i_en   (w_in_run),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_mask         <= '0;
            r_dur          <= '0;
            r_elapsed      <= '0;
            r_tmo          <= '0;
            r_guard        <= '0;
            r_code         <= ST_OK;
            r_status       <= ST_OK;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_start        <= '0;
            r_stop         <= '0;
            r_results      <= '0;
        end else begin
            r_start <= '0;
            r_stop  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_start) begin
                        r_mask         <= bus.port_mask;
                        r_dur          <= bus.duration_ms;
                        r_result_valid <= 1'b0;
                        r_elapsed      <= '0;
                        r_tmo          <= '0;
                        r_busy         <= 1'b1;
                        if (bus.port_mask == '0) begin
                            r_code  <= ST_ABORT;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_WAIT_READY;
                        end
                    end
                end
                S_WAIT_READY: begin
                    if (bus.cmd_abort) begin
                        r_code  <= ST_ABORT;
                        r_state <= S_DONE;
                    end else if (w_gen_ok) begin
                        r_start <= r_mask;
                        r_state <= S_RUN;
                    end else if (w_tmo_hit) begin
                        r_code  <= ST_READY_TO;
                        r_state <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_RUN: begin
                    // The duration compare precedes the tick, so elapsed never overshoots.
                    if (bus.cmd_abort) begin
                        r_stop  <= r_mask;
                        r_code  <= ST_ABORT;
                        r_state <= S_DONE;
                    end else if (r_elapsed == r_dur) begin
                        r_stop  <= r_mask;
                        r_tmo   <= '0;
                        r_guard <= '0;
                        r_state <= S_DRAIN;
                    end else if (w_tick) begin
                        r_elapsed <= r_elapsed + 32'd1;
                    end
                end
                S_DRAIN: begin
                    if (bus.cmd_abort) begin
                        r_code  <= ST_ABORT;
                        r_state <= S_DONE;
                    end else if (w_guard_done && w_drain_ok) begin
                        r_code  <= ST_OK;
                        r_state <= S_DONE;
                    end else if (w_tmo_hit) begin
                        r_code  <= ST_DRAIN_TO;
                        r_state <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                        if (!w_guard_done) r_guard <= r_guard + 1'b1;
                    end
                end
                S_DONE: begin
                    for (int i = 0; i < TEST_PORT_NUM; i++) begin
                        r_results[i] <= r_mask[i] ? bus.check_results[i] : '0;
                    end
                    r_status       <= r_code;
                    r_result_valid <= 1'b1;
                    r_busy         <= 1'b0;
                    r_state        <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.start        = r_start;
    assign bus.stop         = r_stop;
    assign bus.busy         = r_busy;
    assign bus.result_valid = r_result_valid;
    assign bus.status       = r_status;
    assign bus.results      = r_results;
    assign bus.elapsed_ms   = r_elapsed;

endmodule

// File: tb/tb_speed_test_sequencer.sv
// Randomized bench for speed_test_sequencer; expectations come from the
// run/timeout/abort rules evaluated per scenario with plain arithmetic.
module tb_speed_test_sequencer;
    import speed_test_pkg::*;

    localparam int NP  = 4;
    localparam int CF  = 20000;
    localparam int DIV = CF / 1000;
    localparam int RT  = 300;
    localparam int DG  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    speed_test_sequencer_if #(.TEST_PORT_NUM(NP)) bus ();

    speed_test_sequencer #(
        .TEST_PORT_NUM (NP),
        .CLOCK_FREQ    (CF),
        .READY_TIMEOUT (RT),
        .DRAIN_GUARD   (DG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Event log: pulse/fall counts and the cycle each was last seen.
    int          cyc = 0;
    int          ns_tot = 0, np_tot = 0, nd_tot = 0;
    int          t_start_m = 0, t_stop_m = 0, t_done_m = 0;
    logic [NP-1:0] v_start_m = '0, v_stop_m = '0;
    logic        busy_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.start != '0) begin
            ns_tot    <= ns_tot + 1;
            t_start_m <= cyc;
            v_start_m <= bus.start;
        end
        if (bus.stop != '0) begin
            np_tot   <= np_tot + 1;
            t_stop_m <= cyc;
            v_stop_m <= bus.stop;
        end
        if (busy_q && !bus.busy) begin
            nd_tot   <= nd_tot + 1;
            t_done_m <= cyc;
        end
        busy_q <= bus.busy;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // rdy_dly: 0 ready at cmd, >0 raised that many cycles after cmd, <0 never.
    // cr_dly: -2 checkers always ready, -1 never ready after start, >=0 ready
    // that many cycles after stop. abort_at: cycles after start, <0 none.
    task automatic run(input logic [NP-1:0] mask, input int dur, input int rdy_dly,
                       input int cr_dly, input int abort_at, input bit both);
        logic [NP-1:0][127:0] data;
        int   t_cmd, t_rdy, t_ab, ns0, np0, nd0, n, d, lo, exp_ns, exp_el, exp_lat;
        logic [1:0] exp_st;
        bit   ok;
        step();
        for (int i = 0; i < NP; i++) data[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.check_results = data;
        bus.port_mask     = mask;
        bus.duration_ms   = 32'(dur);
        bus.check_ready   = '1;
        bus.gen_ready     = (rdy_dly == 0) ? '1 : ~mask;
        ns0 = ns_tot; np0 = np_tot; nd0 = nd_tot;
        t_rdy = 0; t_ab = 0;
        bus.cmd_start = 1'b1;
        bus.cmd_abort = both;
        t_cmd = cyc;
        step();
        bus.cmd_start = 1'b0;
        bus.cmd_abort = 1'b0;
        chk("busy_rise", 128'(bus.busy), 128'd1);
        chk("rv_clear", 128'(bus.result_valid), 128'd0);

        if (rdy_dly > 0) begin
            while (cyc < t_cmd + rdy_dly) step();
            bus.gen_ready = '1;
            t_rdy = cyc;
        end

        exp_ns = (mask != '0 && rdy_dly >= 0) ? 1 : 0;
        if (exp_ns == 1) begin
            n = 0;
            while (ns_tot == ns0 && n < RT + 50) begin step(); n++; end
            if (cr_dly != -2) bus.check_ready = '0;
            if (abort_at >= 0) begin
                while (cyc < t_start_m + abort_at) step();
                bus.cmd_abort = 1'b1;
                t_ab = cyc;
                step();
                bus.cmd_abort = 1'b0;
            end
            if (cr_dly >= 0) begin
                n = 0;
                while (np_tot == np0 && n < 2000) begin step(); n++; end
                while (cyc < t_stop_m + cr_dly) step();
                bus.check_ready = '1;
            end
        end

        n = 0;
        while (nd_tot == nd0 && n < 3000) begin step(); n++; end
        chk("done_seen", 128'(nd_tot - nd0), 128'd1);

        exp_st = ST_OK;
        if (mask == '0)         exp_st = ST_ABORT;
        else if (rdy_dly < 0)   exp_st = ST_READY_TO;
        else if (abort_at >= 0) exp_st = ST_ABORT;
        else if (cr_dly == -1)  exp_st = ST_DRAIN_TO;
        if (exp_st == ST_OK || exp_st == ST_DRAIN_TO) exp_el = dur;
        else if (exp_ns == 1 && abort_at >= 0)        exp_el = (t_ab - t_start_m) / DIV;
        else                                          exp_el = 0;

        chk("status", 128'(bus.status), 128'(exp_st));
        chk("rvalid", 128'(bus.result_valid), 128'd1);
        chk("busy_fall", 128'(bus.busy), 128'd0);
        chk("elapsed", 128'(bus.elapsed_ms), 128'(exp_el));
        for (int i = 0; i < NP; i++)
            chk($sformatf("result%0d", i), bus.results[i], mask[i] ? data[i] : 128'd0);
        chk("n_start", 128'(ns_tot - ns0), 128'(exp_ns));
        chk("n_stop", 128'(np_tot - np0), 128'(exp_ns));

        if (exp_ns == 1) begin
            exp_lat = (rdy_dly == 0) ? 2 : (t_rdy + 1 - t_cmd);
            chk("start_val", 128'(v_start_m), 128'(mask));
            chk("stop_val", 128'(v_stop_m), 128'(mask));
            chk("start_lat", 128'(t_start_m - t_cmd), 128'(exp_lat));
            if (abort_at >= 0) begin
                chk("abort_stop", 128'(t_stop_m - t_ab), 128'd1);
                chk("abort_done", 128'(t_done_m - t_stop_m), 128'd1);
            end else begin
                d = t_stop_m - t_start_m;
                if (dur == 0) chk("stop_d0", 128'(d), 128'd1);
                else begin
                    ok = (d >= dur * DIV - 1) && (d <= dur * DIV + 1);
                    chk("run_len", 128'(ok), 128'd1);
                end
                d = t_done_m - t_stop_m;
                if (cr_dly == -1) ok = (d >= RT) && (d <= RT + 4);
                else begin
                    lo = (cr_dly > DG) ? cr_dly : DG;
                    ok = (d >= lo) && (d <= lo + 4);
                end
                chk("drain_len", 128'(ok), 128'd1);
            end
        end else if (mask == '0) begin
            ok = (t_done_m - t_cmd) <= 2;
            chk("empty_lat", 128'(ok), 128'd1);
        end else begin
            d = t_done_m - t_cmd;
            ok = (d >= RT) && (d <= RT + 4);
            chk("ready_to_len", 128'(ok), 128'd1);
        end
        bus.check_ready = '1;
        bus.gen_ready   = '1;
    endtask

    initial begin
        int n, ns0, np0;
        logic [NP-1:0] m;
        bus.cmd_start = 1'b0;
        bus.cmd_abort = 1'b0;
        bus.port_mask = '0;
        bus.duration_ms = '0;
        bus.gen_ready = '0;
        bus.check_ready = '0;
        bus.check_results = '0;
        rst = 1'b0;
        repeat (3) step();
        chk("rst_start", 128'(bus.start), 128'd0);
        chk("rst_stop", 128'(bus.stop), 128'd0);
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_rv", 128'(bus.result_valid), 128'd0);
        chk("rst_status", 128'(bus.status), 128'd0);
        chk("rst_elapsed", 128'(bus.elapsed_ms), 128'd0);
        chk("rst_results", 128'(|bus.results), 128'd0);
        rst = 1'b1;

        run(4'b0101, 3, 0, -2, -1, 1'b0);
        run(4'b0100, 2, -1, -2, -1, 1'b0);
        run(4'b1111, 1, 0, 100, -1, 1'b0);
        run(4'b0011, 1, 0, -1, -1, 1'b0);
        run(4'b1111, 3, 0, -2, 10, 1'b0);

        // Reset in the middle of a run: everything clears, no stop follows.
        step();
        bus.port_mask = '1; bus.duration_ms = 32'd5;
        bus.gen_ready = '1; bus.check_ready = '1;
        ns0 = ns_tot;
        bus.cmd_start = 1'b1;
        step();
        bus.cmd_start = 1'b0;
        n = 0;
        while (ns_tot == ns0 && n < 100) begin step(); n++; end
        repeat (5) step();
        np0 = np_tot;
        rst = 1'b0;
        step();
        chk("mid_rst_start", 128'(bus.start), 128'd0);
        chk("mid_rst_stop", 128'(bus.stop), 128'd0);
        chk("mid_rst_busy", 128'(bus.busy), 128'd0);
        chk("mid_rst_rv", 128'(bus.result_valid), 128'd0);
        chk("mid_rst_status", 128'(bus.status), 128'd0);
        chk("mid_rst_elapsed", 128'(bus.elapsed_ms), 128'd0);
        chk("mid_rst_results", 128'(|bus.results), 128'd0);
        rst = 1'b1;
        repeat (8 * DIV) step();
        chk("mid_rst_nostop", 128'(np_tot - np0), 128'd0);
        chk("mid_rst_idle", 128'(bus.busy), 128'd0);

        run(4'b0000, 2, 0, -2, -1, 1'b0);
        run(4'b1001, 0, 0, -2, -1, 1'b0);
        run(4'b0110, 1, 0, -2, -1, 1'b1);
        run(4'b1111, 2, 0, -2, -1, 1'b0);

        for (int k = 0; k < 6; k++) begin
            m = NP'($urandom_range(1, 15));
            run(m, int'($urandom_range(0, 4)),
                ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 20)),
                -2, -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
